game_state_ctrl: RTL

//  Central game sequencer: produces the 2-bit game_state consumed by every sprite/background

---
 rtl/game_state_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/game_state_ctrl.sv
// Game sequencer: INIT/START/END/RESET flow, score, speed level and clear pulse on game_clk.
// Define HIGH_SCORE_EN to add the best-score register; otherwise high_score is tied to zero.
module game_state_ctrl #(
  parameter int TICKS_PER_POINT  = 6,
  parameter int SCORE_MAX        = 9999,
  parameter int POINTS_PER_LEVEL = 100,
  parameter int MAX_LEVEL        = 7,
  parameter int END_HOLD         = 60,
  parameter int RESET_CYCLES     = 4
) (
  input  logic        game_clk,
  input  logic        rst,
  input  logic        key_start,
  input  logic        collision,
  output logic [1:0]  game_state,
  output logic [13:0] score,
  output logic [13:0] high_score,
  output logic [2:0]  speed_level,
  output logic        clear_pulse
);
  localparam int TW = (TICKS_PER_POINT > 1) ? $clog2(TICKS_PER_POINT) : 1;
  localparam int DW = $clog2(END_HOLD + 1);
  localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_START = 2'd1,
    ST_END   = 2'd2,
    ST_RESET = 2'd3
  } state_e;

  state_e        state_q;
  logic [13:0]   score_q;
  logic [13:0]   bound_q;
  logic [2:0]    level_q;
  logic          clear_q;
  logic          key_q;
  logic [TW-1:0] tick_q;
  logic [DW-1:0] dwell_q;
  logic [RW-1:0] rcnt_q;
`ifdef HIGH_SCORE_EN
  logic [13:0]   high_q;
`endif

  logic          key_rise;
  logic          tick_wrap;
  logic          dwell_done;
  logic          level_step;
  logic [TW-1:0] tick_d;
  logic [13:0]   score_d;

  assign key_rise   = key_start & ~key_q;
  assign tick_wrap  = (tick_q == TW'(TICKS_PER_POINT - 1));
  assign tick_d     = tick_wrap ? '0 : tick_q + 1'b1;
  assign score_d    = (score_q == 14'(SCORE_MAX)) ? score_q : score_q + 14'd1;
  assign dwell_done = (dwell_q == DW'(END_HOLD));
  // bound_q is the score at which the next level starts; score moves by at most one per cycle
  assign level_step = (level_q != 3'(MAX_LEVEL)) && (score_q >= bound_q);

  always_ff @(posedge game_clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      score_q <= '0;
      bound_q <= 14'(POINTS_PER_LEVEL);
      level_q <= '0;
      clear_q <= 1'b0;
      key_q   <= 1'b0;
      tick_q  <= '0;
      dwell_q <= '0;
      rcnt_q  <= '0;
`ifdef HIGH_SCORE_EN
      high_q  <= '0;
`endif
    end else begin
      key_q   <= key_start;
      clear_q <= 1'b0;
      if (level_step) begin
        level_q <= level_q + 3'd1;
        bound_q <= bound_q + 14'(POINTS_PER_LEVEL);
      end
      case (state_q)
        ST_INIT: begin
          if (key_rise) state_q <= ST_START;
        end
        ST_START: begin
          tick_q <= tick_d;
          if (collision) begin
            // collision beats a point scheduled in the same cycle
            state_q <= ST_END;
            dwell_q <= '0;
`ifdef HIGH_SCORE_EN
            if (score_q > high_q) high_q <= score_q;
`endif
          end else if (tick_wrap) begin
            score_q <= score_d;
          end
        end
        ST_END: begin
          if (key_rise && dwell_done) begin
            state_q <= ST_RESET;
            clear_q <= 1'b1;
            score_q <= '0;
            tick_q  <= '0;
            level_q <= '0;
            bound_q <= 14'(POINTS_PER_LEVEL);
            rcnt_q  <= '0;
          end else if (!dwell_done) begin
            dwell_q <= dwell_q + 1'b1;
          end
        end
        default: begin
          if (rcnt_q == RW'(RESET_CYCLES - 1)) state_q <= ST_START;
          else rcnt_q <= rcnt_q + 1'b1;
        end
      endcase
    end
  end

  assign game_state  = state_q;
  assign score       = score_q;
  assign speed_level = level_q;
  assign clear_pulse = clear_q;
`ifdef HIGH_SCORE_EN
  assign high_score  = high_q;
`else
  assign high_score  = 14'd0;
`endif

endmodule
